// File: rtl/robo_tube_world_if.sv
// rtl/robo_tube_world_if.sv - controller/map-loader bundle for the robot tube world
interface robo_tube_world_if;
    logic       front;
    logic       turn;
    logic       remove;
    logic       map_we;
    logic [5:0] map_addr;
    logic [1:0] map_data;
    logic       start;
    logic       head;
    logic       left;
    logic       under;
    logic       barrier;
    logic       err;
    logic       done;
    logic [7:0] moves;
    logic [5:0] trash_cnt;

    modport master (
        output front, turn, remove, map_we, map_addr, map_data, start,
        input  head, left, under, barrier, err, done, moves, trash_cnt
    );

    modport slave (
        input  front, turn, remove, map_we, map_addr, map_data, start,
        output head, left, under, barrier, err, done, moves, trash_cnt
    );
endinterface

// File: rtl/robo_tube_world.sv
// rtl/robo_tube_world.sv - 8x8 pipe world with a robot cleaning trash cells
// Optional macro ROBO_WORLD_ERRCHK_EN enables illegal-command detection on err.
module robo_tube_world #(
    parameter logic [3:0] REMOVE_LEN = 4'd3,
    parameter logic [2:0] START_X    = 3'd0,
    parameter logic [2:0] START_Y    = 3'd0,
    parameter logic [1:0] START_DIR  = 2'd1,
    parameter logic [2:0] EXIT_X     = 3'd7,
    parameter logic [2:0] EXIT_Y     = 3'd7
) (
    input  logic               clock,
    input  logic               reset,
    robo_tube_world_if.slave   bus
);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] pos_x;
    logic [2:0] pos_y;
    logic [1:0] dir;
    logic [1:0] cells [64];
    logic [3:0] rm_cnt;
    logic [7:0] moves_q;
    logic [5:0] trash_q;
    logic       err_q;

    // Returns {outside, y, x} of the neighbour in direction d.
    function automatic logic [6:0] neighbor(input logic [2:0] x, input logic [2:0] y,
                                            input logic [1:0] d);
        logic       out;
        logic [2:0] nx;
        logic [2:0] ny;
        out = 1'b0;
        nx  = x;
        ny  = y;
        case (d)
            2'd0: begin out = (y == 3'd0); ny = y - 3'd1; end
            2'd1: begin out = (x == 3'd7); nx = x + 3'd1; end
            2'd2: begin out = (y == 3'd7); ny = y + 3'd1; end
            default: begin out = (x == 3'd0); nx = x - 3'd1; end
        endcase
        return {out, ny, nx};
    endfunction

    logic [6:0] front_nb;
    logic [6:0] left_nb;
    logic [1:0] front_cell;
    logic [1:0] left_cell;
    logic       front_free;
    logic       active;
    logic       do_move;
    logic       do_turn;
    logic       do_rm;
    logic       rm_done;
    logic       cmd_err;

    assign front_nb   = neighbor(pos_x, pos_y, dir);
    assign left_nb    = neighbor(pos_x, pos_y, dir - 2'd1);
    assign front_cell = front_nb[6] ? 2'b01 : cells[front_nb[5:0]];
    assign left_cell  = left_nb[6]  ? 2'b01 : cells[left_nb[5:0]];
    assign front_free = (front_cell == 2'b00);

    assign bus.head    = front_cell[0];
    assign bus.barrier = (front_cell == 2'b10);
    assign bus.left    = left_cell[0];
    assign bus.under   = (pos_x == EXIT_X) && (pos_y == EXIT_Y);

    // Commands are only executed in RUN while the robot is not yet on the exit.
    assign active = (state == S_RUN) && !bus.under;

`ifdef ROBO_WORLD_ERRCHK_EN
    logic [1:0] n_cmd;
    logic       single;
    assign n_cmd   = {1'b0, bus.front} + {1'b0, bus.turn} + {1'b0, bus.remove};
    assign single  = (n_cmd == 2'd1);
    assign do_turn = active && single && bus.turn;
    assign do_move = active && single && bus.front && front_free;
    assign do_rm   = active && single && bus.remove && bus.barrier;
    assign cmd_err = active && ((n_cmd > 2'd1) ||
                                (single && bus.front && !front_free) ||
                                (single && bus.remove && !bus.barrier));
`else
    assign do_rm   = active && bus.remove && bus.barrier;
    assign do_turn = active && !bus.remove && bus.turn;
    assign do_move = active && !bus.remove && !bus.turn && bus.front && front_free;
    assign cmd_err = 1'b0;
`endif

    assign rm_done = do_rm && ((rm_cnt + 4'd1) == REMOVE_LEN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:  if (bus.start) state_nx = S_RUN;
            S_RUN:   if (bus.under) state_nx = S_DONE;
            default: state_nx = S_DONE;
        endcase
    end

    always_comb begin
        bus.done = (state == S_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_x   <= START_X;
            pos_y   <= START_Y;
            dir     <= START_DIR;
            rm_cnt  <= 4'd0;
            moves_q <= 8'd0;
            trash_q <= 6'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < 64; i++) cells[i] <= 2'b00;
        end else begin
            err_q <= cmd_err;
            if ((state == S_LOAD) && bus.map_we)
                cells[bus.map_addr] <= bus.map_data;
            if (do_move) begin
                pos_x <= front_nb[2:0];
                pos_y <= front_nb[5:3];
                if (moves_q != 8'd255) moves_q <= moves_q + 8'd1;
            end
            if (do_turn) dir <= dir + 2'd1;
            if (rm_done) begin
                rm_cnt                <= 4'd0;
                cells[front_nb[5:0]]  <= 2'b00;
                if (trash_q != 6'd63) trash_q <= trash_q + 6'd1;
            end else if (do_rm) begin
                rm_cnt <= rm_cnt + 4'd1;
            end else begin
                rm_cnt <= 4'd0;
            end
        end
    end

    assign bus.err       = err_q;
    assign bus.moves     = moves_q;
    assign bus.trash_cnt = trash_q;

endmodule
